// File: rtl/sm3_pkg.sv
// Shared SM3 package.
// Holds the common word and block types, the expansion FSM state enum and
// the XOR/rotate helpers. The compression core uses the same helpers.
//   sm3_word_t      32-bit message/expansion word
//   sm3_blk_t       16 words = one 512-bit block
//   sm3_expnd_st_e  LOAD (collecting W0..W15) / EXPAND (emitting beats)
//   rotl32(x, n)    32-bit rotate left, n in 0..31
//   p1(x)           permutation P1(x) = x ^ rotl(x,15) ^ rotl(x,23)
package sm3_pkg;

    localparam int SM3_BLK_WORDS = 16;

    typedef logic [31:0] sm3_word_t;
    typedef sm3_word_t [SM3_BLK_WORDS-1:0] sm3_blk_t;

    typedef enum logic {
        LOAD   = 1'b0,
        EXPAND = 1'b1
    } sm3_expnd_st_e;

    function automatic sm3_word_t rotl32(input sm3_word_t x, input logic [4:0] n);
        // When n = 0, the right shift by 32 yields 0, so the result is x itself.
        return (x << n) | (x >> (6'd32 - {1'b0, n}));
    endfunction

    function automatic sm3_word_t p1(input sm3_word_t x);
        return x ^ rotl32(x, 5'd15) ^ rotl32(x, 5'd23);
    endfunction

endpackage

// File: rtl/sm3_expnd_core_if.sv
// Bus between the padding stage, the expansion core and the compression core.
//   pad_inpt_*    word stream from the padding stage (valid/ready)
//   expnd_otpt_*  expansion beats toward the compression core (valid only,
//                 no back-pressure)
// Modports:
//   slave   the expansion core's view
//   master  the environment's view (padding stage plus compression core)
interface sm3_expnd_core_if;
    import sm3_pkg::*;

    sm3_word_t pad_inpt_d_i;
    logic      pad_inpt_vld_i;
    logic      pad_inpt_msg_lst_i;
    logic      pad_inpt_rdy_o;
    sm3_word_t expnd_otpt_wj_o;
    sm3_word_t expnd_otpt_wjj_o;
    logic      expnd_otpt_lst_o;
    logic      expnd_otpt_msg_lst_o;
    logic      expnd_otpt_vld_o;

    modport slave (
        input  pad_inpt_d_i, pad_inpt_vld_i, pad_inpt_msg_lst_i,
        output pad_inpt_rdy_o,
        output expnd_otpt_wj_o, expnd_otpt_wjj_o, expnd_otpt_lst_o,
        output expnd_otpt_msg_lst_o, expnd_otpt_vld_o
    );

    modport master (
        output pad_inpt_d_i, pad_inpt_vld_i, pad_inpt_msg_lst_i,
        input  pad_inpt_rdy_o,
        input  expnd_otpt_wj_o, expnd_otpt_wjj_o, expnd_otpt_lst_o,
        input  expnd_otpt_msg_lst_o, expnd_otpt_vld_o
    );

endinterface

// File: rtl/sm3_expnd_wgen.sv
// Combinational next-word generator for the SM3 message expansion.
// With the window positioned so that w0 = W_{j-16}, the generator gives:
//   w16 = P1(w0 ^ w7 ^ rotl(w13,15)) ^ rotl(w3,7) ^ w10
// Ports:
//   w0, w3, w7, w10, w13  in   window taps
//   w16                   out  new word for the top of the window
module sm3_expnd_wgen
    import sm3_pkg::*;
(
    input  sm3_word_t w0,
    input  sm3_word_t w3,
    input  sm3_word_t w7,
    input  sm3_word_t w10,
    input  sm3_word_t w13,
    output sm3_word_t w16
);

    assign w16 = p1(w0 ^ w7 ^ rotl32(w13, 5'd15)) ^ rotl32(w3, 5'd7) ^ w10;

endmodule

// File: rtl/sm3_expnd_core.sv
// SM3 message-expansion engine.
// The core loads W0..W15 into a 16-word shift window. It then emits ROUNDS
// beats of (W_j, W'_j = W_j ^ W_{j+4}), one beat per cycle, and marks the
// last beat of every block (lst) and of every message (msg_lst).
// Ports:
//   clk    in  clock
//   rst_n  in  asynchronous active-low reset; aborts any block in progress
//   bus    slave modport of sm3_expnd_core_if (pad_inpt_* in, expnd_otpt_* out)
// Parameters:
//   ROUNDS  number of expansion beats per block (64 in product)
module sm3_expnd_core
    import sm3_pkg::*;
#(
    parameter int ROUNDS = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    sm3_expnd_core_if.slave    bus
);

    localparam int RW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
    localparam logic [RW-1:0] R_LAST = RW'(ROUNDS - 1);

    sm3_expnd_st_e state_reg, state_next;
    logic [3:0]    word_cnt_reg;
    logic [RW-1:0] rnd_cnt_reg;
    logic          msg_lst_reg;
    sm3_word_t     w_reg [SM3_BLK_WORDS];
    sm3_word_t     w_new;

    logic accept;
    logic expanding;
    logic last_word;
    logic last_rnd;

    // Next-state logic. Valid is ignored outside LOAD, so a word is only
    // accepted while the core is collecting.
    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        expanding  = 1'b0;
        case (state_reg)
            LOAD: begin
                accept = bus.pad_inpt_vld_i;
                if (accept && last_word) begin
                    state_next = EXPAND;
                end
            end
            EXPAND: begin
                expanding = 1'b1;
                if (last_rnd) begin
                    state_next = LOAD;
                end
            end
            default: state_next = LOAD;
        endcase
    end

    assign last_word = (word_cnt_reg == 4'd15);
    assign last_rnd  = (rnd_cnt_reg == R_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= LOAD;
            word_cnt_reg <= '0;
            rnd_cnt_reg  <= '0;
            msg_lst_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            // The 4-bit counter wraps 15->0 on the same edge that enters EXPAND.
            if (accept) begin
                word_cnt_reg <= word_cnt_reg + 4'd1;
            end
            if (expanding && !last_rnd) begin
                rnd_cnt_reg <= rnd_cnt_reg + RW'(1);
            end else begin
                rnd_cnt_reg <= '0;
            end
            if (accept && last_word) begin
                msg_lst_reg <= bus.pad_inpt_msg_lst_i;
            end
        end
    end

    sm3_expnd_wgen u_wgen (
        .w0  (w_reg[0]),
        .w3  (w_reg[3]),
        .w7  (w_reg[7]),
        .w10 (w_reg[10]),
        .w13 (w_reg[13]),
        .w16 (w_new)
    );

    // The window shifts toward w[0] both when loading and when expanding.
    // Only the word that enters at w[15] differs between the two cases.
    generate
        for (genvar gi = 0; gi < SM3_BLK_WORDS - 1; gi++) begin : g_win
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    w_reg[gi] <= '0;
                end else if (accept || expanding) begin
                    w_reg[gi] <= w_reg[gi+1];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_reg[SM3_BLK_WORDS-1] <= '0;
        end else if (accept) begin
            w_reg[SM3_BLK_WORDS-1] <= bus.pad_inpt_d_i;
        end else if (expanding) begin
            w_reg[SM3_BLK_WORDS-1] <= w_new;
        end
    end

    // All outputs are decoded from registers only. Because the reset is
    // asynchronous, vld and lst drop as soon as rst_n falls.
    assign bus.pad_inpt_rdy_o       = (state_reg == LOAD);
    assign bus.expnd_otpt_vld_o     = (state_reg == EXPAND);
    assign bus.expnd_otpt_wj_o      = w_reg[0];
    assign bus.expnd_otpt_wjj_o     = w_reg[0] ^ w_reg[4];
    assign bus.expnd_otpt_lst_o     = (state_reg == EXPAND) && last_rnd;
    assign bus.expnd_otpt_msg_lst_o = (state_reg == EXPAND) && last_rnd && msg_lst_reg;

endmodule

// File: tb/tb_sm3_expnd_core.sv
// Self-checking bench for sm3_expnd_core.
// A reference model computes W0..W67 of each block straight from the
// recurrence. The expected beats are queued, and a negedge compare process
// checks every valid beat against the queue, along with rdy/vld exclusivity
// and the lst flags.
module tb_sm3_expnd_core;

    localparam int ROUNDS = 64;

    typedef struct {
        logic [31:0] wj;
        logic [31:0] wjj;
        logic [1:0]  flags;   // {lst, msg_lst}
        int          j;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    sm3_expnd_core_if bus ();

    sm3_expnd_core #(.ROUNDS(ROUNDS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    int          beats_seen = 0;
    beat_t       exp_q [$];
    logic [31:0] blk_words [16];
    logic [31:0] m_w [68];
    logic [31:0] obs_wj  [ROUNDS];
    logic [31:0] obs_wjj [ROUNDS];
    logic [1:0]  obs_fl  [ROUNDS];
    logic [31:0] abc [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] rl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [31:0] p1m(input logic [31:0] x);
        return x ^ rl(x, 15) ^ rl(x, 23);
    endfunction

    // Reference expansion: the textbook recurrence over a flat 68-word array.
    task automatic build_model();
        for (int j = 0; j < 16; j++) m_w[j] = blk_words[j];
        for (int j = 16; j < 68; j++)
            m_w[j] = p1m(m_w[j-16] ^ m_w[j-9] ^ rl(m_w[j-3], 15)) ^ rl(m_w[j-13], 7) ^ m_w[j-6];
    endtask

    task automatic push_expected(input bit ml);
        beat_t b;
        for (int j = 0; j < ROUNDS; j++) begin
            b.wj    = m_w[j];
            b.wjj   = m_w[j] ^ m_w[j+4];
            b.flags = {j == ROUNDS-1, ml && (j == ROUNDS-1)};
            b.j     = j;
            exp_q.push_back(b);
        end
    endtask

    // Compare process. It runs on every cycle out of reset.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("rdy_vs_vld", {31'd0, bus.pad_inpt_rdy_o}, {31'd0, ~bus.expnd_otpt_vld_o});
            if (bus.expnd_otpt_vld_o === 1'b1) begin
                beats_seen++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 32'd1, 32'd0);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    chk($sformatf("wj[%0d]", e.j), bus.expnd_otpt_wj_o, e.wj);
                    chk($sformatf("wjj[%0d]", e.j), bus.expnd_otpt_wjj_o, e.wjj);
                    chk($sformatf("flags[%0d]", e.j),
                        {30'd0, bus.expnd_otpt_lst_o, bus.expnd_otpt_msg_lst_o}, {30'd0, e.flags});
                    obs_wj[e.j]  = bus.expnd_otpt_wj_o;
                    obs_wjj[e.j] = bus.expnd_otpt_wjj_o;
                    obs_fl[e.j]  = {bus.expnd_otpt_lst_o, bus.expnd_otpt_msg_lst_o};
                end
            end else begin
                chk("idle_flags", {30'd0, bus.expnd_otpt_lst_o, bus.expnd_otpt_msg_lst_o}, 32'd0);
            end
        end
    end

    // Feeds `nwords` words of blk_words. Called and returns at posedge+1.
    // The block's expected beats are pushed when its 16th word is accepted.
    task automatic feed_words(input int nwords, input bit ml, input int maxgap, input bit push);
        int cnt;
        for (int k = 0; k < ROUNDS; k++) obs_wj[k] = 'x;
        build_model();
        for (int i = 0; i < nwords; i++) begin
            repeat ($urandom_range(0, maxgap)) @(posedge clk);
            #1;
            bus.pad_inpt_vld_i     = 1'b1;
            bus.pad_inpt_d_i       = blk_words[i];
            bus.pad_inpt_msg_lst_i = (i == 15) ? ml : 1'($urandom_range(0, 1));
            cnt = 0;
            @(negedge clk);
            while (bus.pad_inpt_rdy_o !== 1'b1 && cnt < 200) begin
                @(negedge clk);
                cnt++;
            end
            if (cnt >= 200) chk("rdy_timeout", 32'd0, 32'd1);
            @(posedge clk);
            if (i == 15 && push) push_expected(ml);
            #1;
            bus.pad_inpt_vld_i = 1'b0;
            #0;
        end
    endtask

    task automatic drain();
        int cnt = 0;
        while (exp_q.size() != 0 && cnt < ROUNDS + 50) begin
            @(posedge clk);
            cnt++;
        end
        if (exp_q.size() != 0) begin
            chk("beats_missing", exp_q.size(), 32'd0);
            exp_q.delete();
        end
        #1;
    endtask

    task automatic junk_pulses();
        repeat (5) begin
            bus.pad_inpt_vld_i = 1'b1;
            bus.pad_inpt_d_i   = $urandom;
            @(posedge clk);
            #1;
        end
        bus.pad_inpt_vld_i = 1'b0;
    endtask

    task automatic abort_reset(input string tag);
        #1 rst_n = 1'b0;
        #1;
        chk({tag, "_vld"}, {31'd0, bus.expnd_otpt_vld_o}, 32'd0);
        chk({tag, "_rdy"}, {31'd0, bus.pad_inpt_rdy_o}, 32'd1);
        chk({tag, "_wj"}, bus.expnd_otpt_wj_o, 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic check_abc(input string tag, input int b0);
        chk({tag, "_beat0_wj"}, obs_wj[0], 32'h61626380);
        chk({tag, "_beat0_wjj"}, obs_wjj[0], 32'h61626380);
        chk({tag, "_beat16_wj"}, obs_wj[16], 32'h9092E200);
        chk({tag, "_beat63_flags"}, {30'd0, obs_fl[63]}, 32'd3);
        chk({tag, "_beat_count"}, beats_seen - b0, 32'd64);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        int b0;
        bus.pad_inpt_vld_i     = 1'b0;
        bus.pad_inpt_d_i       = '0;
        bus.pad_inpt_msg_lst_i = 1'b0;
        abc[0] = 32'h61626380;
        for (int i = 1; i < 15; i++) abc[i] = 32'h0;
        abc[15] = 32'h00000018;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdy", {31'd0, bus.pad_inpt_rdy_o}, 32'd1);
        chk("rst_vld", {31'd0, bus.expnd_otpt_vld_o}, 32'd0);
        chk("rst_lst", {30'd0, bus.expnd_otpt_lst_o, bus.expnd_otpt_msg_lst_o}, 32'd0);
        chk("rst_wj", bus.expnd_otpt_wj_o, 32'd0);
        chk("rst_wjj", bus.expnd_otpt_wjj_o, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Pin the model against hand-known "abc" values.
        blk_words = abc;
        build_model();
        chk("model_w0", m_w[0], 32'h61626380);
        chk("model_w16", m_w[16], 32'h9092E200);
        chk("model_wjj0", m_w[0] ^ m_w[4], 32'h61626380);

        // 1: "abc" block with no gaps.
        b0 = beats_seen;
        feed_words(16, 1'b1, 0, 1'b1);
        drain();
        check_abc("s1", b0);

        // 2: random gaps between words, and vld pulses during EXPAND.
        b0 = beats_seen;
        feed_words(16, 1'b1, 3, 1'b1);
        junk_pulses();
        drain();
        check_abc("s2", b0);

        // 3: two back-to-back blocks, msg_lst 0 then 1.
        for (int i = 0; i < 16; i++) blk_words[i] = $urandom;
        feed_words(16, 1'b0, 0, 1'b1);
        drain();
        chk("s3_blk1_flags", {30'd0, obs_fl[63]}, 32'd2);
        feed_words(16, 1'b1, 0, 1'b1);
        drain();
        chk("s3_blk2_flags", {30'd0, obs_fl[63]}, 32'd3);

        // 4: reset at word 9 of LOAD, then at round 30 of EXPAND.
        blk_words = abc;
        feed_words(9, 1'b1, 0, 1'b0);
        abort_reset("s4_load");
        feed_words(16, 1'b1, 0, 1'b1);
        begin
            int cnt = 0;
            while (exp_q.size() > ROUNDS - 30 && cnt < 100) begin
                @(posedge clk);
                cnt++;
            end
        end
        abort_reset("s4_expand");
        b0 = beats_seen;
        feed_words(16, 1'b1, 0, 1'b1);
        drain();
        check_abc("s4_clean", b0);

        // 5: random blocks.
        for (int n = 0; n < 200; n++) begin
            for (int i = 0; i < 16; i++) blk_words[i] = $urandom;
            b0 = beats_seen;
            feed_words(16, 1'($urandom_range(0, 1)), (n % 3 == 0) ? 2 : 0, 1'b1);
            drain();
            chk("s5_beat_count", beats_seen - b0, 32'd64);
        end

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
